// File: rtl/sram_ctrl.sv
// sram_ctrl: turns one 32-bit core load/store into two 16-bit SRAM phases, low half first.
// Optional build macro SRAM_CTRL_RANGE_CHECK_EN adds range_err and rejects out-of-window addresses.
module sram_ctrl #(
    parameter int unsigned PHASE_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR    = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    ,
    output logic        range_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(PHASE_CYCLES - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_phase;
    logic [16:0] r_idx;
    logic [31:0] r_wdata;
    logic        r_isWrite;
    logic [31:0] r_readData;

    logic        w_req;
    logic [31:0] w_offset;
    logic [16:0] w_reqIdx;
    logic        w_lastPhase;
    logic        w_active;
    logic        w_drive;
    logic        w_rangeBad;
    logic        w_accept;
    logic        w_unused;

    assign w_req       = rd_en | wr_en;
    assign w_offset    = address - BASE_ADDR;
    assign w_reqIdx    = w_offset[18:2];
    assign w_lastPhase = (r_phase == LP_LAST);
    assign w_active    = (r_state == S_LOW) || (r_state == S_HIGH);
    assign w_drive     = w_active & r_isWrite;
    assign w_accept    = (r_state == S_IDLE) & w_req;
    assign w_unused    = &{1'b0, address[1:0], w_offset[31:19], w_offset[1:0]};

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    // Anything below the base or past the 2^17-word window is rejected before touching the SRAM.
    assign w_rangeBad = (address < BASE_ADDR) | (|w_offset[31:19]);
`else
    assign w_rangeBad = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_nextState = w_rangeBad ? S_DONE : S_LOW;
                end
            end
            S_LOW: begin
                if (w_lastPhase) begin
                    w_nextState = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_lastPhase) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase <= 4'd0;
        end else if (w_active && !w_lastPhase) begin
            r_phase <= r_phase + 4'd1;
        end else begin
            r_phase <= 4'd0;
        end
    end

    // Request is frozen on leaving IDLE so the core may change its inputs freely afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= 17'd0;
            r_wdata   <= 32'd0;
            r_isWrite <= 1'b0;
        end else if (w_accept) begin
            r_idx     <= w_reqIdx;
            r_wdata   <= write_data;
            r_isWrite <= wr_en;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_readData <= 32'd0;
        end else if (w_accept && w_rangeBad) begin
            r_readData <= 32'd0;
        end else if (r_state == S_LOW && w_lastPhase && !r_isWrite) begin
            r_readData[15:0] <= SRAM_DQ;
        end else if (r_state == S_HIGH && w_lastPhase && !r_isWrite) begin
            r_readData[31:16] <= SRAM_DQ;
        end
    end

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic r_rangeErr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rangeErr <= 1'b0;
        end else begin
            r_rangeErr <= w_accept & w_rangeBad;
        end
    end

    assign range_err = r_rangeErr;
`endif

    always_comb begin
        SRAM_ADDR = 18'd0;
        if (r_state == S_LOW) begin
            SRAM_ADDR = {r_idx, 1'b0};
        end else if (r_state == S_HIGH) begin
            SRAM_ADDR = {r_idx, 1'b1};
        end
    end

    assign SRAM_DQ   = w_drive ? ((r_state == S_HIGH) ? r_wdata[31:16] : r_wdata[15:0]) : 16'hzzzz;
    assign SRAM_WE_N = ~w_drive;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign read_data = r_readData;
    assign ready     = (r_state == S_DONE) | ((r_state == S_IDLE) & ~w_req);

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed self-checking bench for sram_ctrl against a small behavioural SRAM.
// Define SRAM_CTRL_RANGE_CHECK_EN to also exercise range_err.
module tb_sram_ctrl;

    localparam int P = 3;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic        range_err;
`endif

    int vectorCount;
    int miscompareCount;

    logic [15:0] sram [0:1023];

    int          readyAt;
    logic [31:0] rdData;
    logic [17:0] loAddr;
    logic [17:0] hiAddr;
    logic        sawWe;
    logic        errAtReady;
    logic [15:0] snap5;
    logic [15:0] snap8;
    int          pulseAt [3];
    logic [31:0] pulseData [3];
    int          np;
    logic        sawReady;

    sram_ctrl #(
        .PHASE_CYCLES(P),
        .BASE_ADDR   (32'd1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .ready     (ready),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_WE_N (SRAM_WE_N)
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        ,
        .range_err (range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives the bus only while the controller is not writing.
    assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR[9:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_WE_N) sram[SRAM_ADDR[9:0]] <= SRAM_DQ;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // One access from IDLE; readyAt counts cycles from the IDLE cycle where the request appears.
    task automatic applyStimulus(input logic doWr, input logic doRd, input logic [31:0] addr,
                                 input logic [31:0] data);
        @(posedge clk);
        #1;
        wr_en      = doWr;
        rd_en      = doRd;
        address    = addr;
        write_data = data;
        readyAt    = -1;
        rdData     = 32'd0;
        loAddr     = 18'd0;
        hiAddr     = 18'd0;
        sawWe      = 1'b0;
        errAtReady = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (!SRAM_WE_N) sawWe = 1'b1;
            if (cyc == 1) loAddr = SRAM_ADDR;
            if (cyc == P + 1) hiAddr = SRAM_ADDR;
            if (ready) begin
                readyAt = cyc;
                rdData  = read_data;
`ifdef SRAM_CTRL_RANGE_CHECK_EN
                errAtReady = range_err;
`endif
                break;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        rst        = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
        sram[3] = 16'hFFFF;
        sram[4] = 16'h3344;
        sram[5] = 16'h1122;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstReady", {31'd0, ready}, 32'd1);
        checkOutput("rstWeN", {31'd0, SRAM_WE_N}, 32'd1);
        checkOutput("rstReadData", read_data, 32'd0);
        checkOutput("rstAddr", {14'd0, SRAM_ADDR}, 32'd0);
        checkOutput("tiedStrobes", {28'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'd0);

        // Reset lands in cycle 2 of a write; the high half must never be written.
        @(posedge clk);
        #1;
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'h11112222;
        repeat (3) @(negedge clk);
        checkOutput("midWeLow", {31'd0, SRAM_WE_N}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("midRstWeN", {31'd0, SRAM_WE_N}, 32'd1);
        checkOutput("midRstAddr", {14'd0, SRAM_ADDR}, 32'd0);
        wr_en = 1'b0;
        #1;
        checkOutput("midRstReady", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abortHigh", {16'd0, sram[9]}, 32'd0);
        checkOutput("idleReady", {31'd0, ready}, 32'd1);

        applyStimulus(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        checkOutput("wrLatency", readyAt, 32'd7);
        checkOutput("wrSram0", {16'd0, sram[0]}, 32'h0000BEEF);
        checkOutput("wrSram1", {16'd0, sram[1]}, 32'h0000DEAD);
        checkOutput("wrKeepsRd", rdData, 32'd0);
        checkOutput("wrRangeErr", {31'd0, errAtReady}, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'd1024, 32'd0);
        checkOutput("rdLatency", readyAt, 32'd7);
        checkOutput("rdData", rdData, 32'hDEADBEEF);
        checkOutput("rdNoWe", {31'd0, sawWe}, 32'd0);

        snap5 = sram[5];
        snap8 = sram[8];
        applyStimulus(1'b1, 1'b0, 32'd1036, 32'h12345678);
        checkOutput("mapLatency", readyAt, 32'd7);
        checkOutput("mapLoAddr", {14'd0, loAddr}, 32'd6);
        checkOutput("mapHiAddr", {14'd0, hiAddr}, 32'd7);
        checkOutput("mapSram6", {16'd0, sram[6]}, 32'h00005678);
        checkOutput("mapSram7", {16'd0, sram[7]}, 32'h00001234);
        checkOutput("mapSram5", {16'd0, sram[5]}, {16'd0, snap5});
        checkOutput("mapSram8", {16'd0, sram[8]}, {16'd0, snap8});

        applyStimulus(1'b1, 1'b1, 32'd1028, 32'h0000A5A5);
        checkOutput("bothLatency", readyAt, 32'd7);
        checkOutput("bothWe", {31'd0, sawWe}, 32'd1);
        checkOutput("bothSram2", {16'd0, sram[2]}, 32'h0000A5A5);
        checkOutput("bothSram3", {16'd0, sram[3]}, 32'h00000000);
        checkOutput("bothReadData", rdData, 32'hDEADBEEF);

        // Three reads with rd_en held; the next address appears right after each ready edge.
        np = 0;
        for (int k = 0; k < 3; k++) begin
            pulseAt[k]   = -1;
            pulseData[k] = 32'd0;
        end
        @(posedge clk);
        #1;
        rd_en   = 1'b1;
        address = 32'd1024;
        for (int cyc = 0; cyc < 40 && np < 3; cyc++) begin
            @(negedge clk);
            sawReady = ready;
            if (ready) begin
                pulseAt[np]   = cyc;
                pulseData[np] = read_data;
                np++;
            end
            @(posedge clk);
            #1;
            if (sawReady) begin
                if (np < 3) address = 32'd1024 + 32'(4 * np);
                else rd_en = 1'b0;
            end
        end
        rd_en = 1'b0;
        checkOutput("b2bPulses", np, 32'd3);
        checkOutput("b2bPulse0", pulseAt[0], 32'd7);
        checkOutput("b2bPulse1", pulseAt[1], 32'd15);
        checkOutput("b2bPulse2", pulseAt[2], 32'd23);
        checkOutput("b2bData0", pulseData[0], 32'hDEADBEEF);
        checkOutput("b2bData1", pulseData[1], 32'h0000A5A5);
        checkOutput("b2bData2", pulseData[2], 32'h11223344);

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        applyStimulus(1'b0, 1'b1, 32'd512, 32'd0);
        checkOutput("rangeLatency", readyAt, 32'd1);
        checkOutput("rangeErr", {31'd0, errAtReady}, 32'd1);
        checkOutput("rangeReadData", rdData, 32'd0);
        checkOutput("rangeNoWe", {31'd0, sawWe}, 32'd0);
        @(negedge clk);
        checkOutput("rangeErrClears", {31'd0, range_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
